// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// The cache uses the slave view; the fetch stage and memory port use the master view.
interface icache_if;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush;
    logic        icache_mem_req;
    logic [31:0] icache_mem_addr;
    logic [31:0] icache_mem_rdata;
    logic        icache_mem_ready;

    modport slave (
        input  cpu_req, cpu_addr, flush, icache_mem_rdata, icache_mem_ready,
        output cpu_rdata, cpu_ready, icache_mem_req, icache_mem_addr
    );

    modport master (
        output cpu_req, cpu_addr, flush, icache_mem_rdata, icache_mem_ready,
        input  cpu_rdata, cpu_ready, icache_mem_req, icache_mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache.
// Hits answer combinationally in the request cycle. Misses refill a whole line
// one word at a time. Memory ready is ignored in the first cycle after each
// refill address change, because the memory's ready flag is one cycle stale.
module icache #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic     clk,
    input  logic     rst,
    icache_if.slave  bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_REFILL = 1'b1;

    localparam logic [OFF_W-1:0] CNT_ZERO = {OFF_W{1'b0}};
    localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);
    localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);

    logic [0:0]       state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic             blank_q, blank_d;
    logic             flushed_q, flushed_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [NUM_LINES];
    logic [TAG_W-1:0] tag_d  [NUM_LINES];
    logic [31:0]      data_q [NUM_LINES][LINE_WORDS];
    logic [31:0]      data_d [NUM_LINES][LINE_WORDS];

    logic [IDX_W-1:0] cpu_idx_s;
    logic [OFF_W-1:0] cpu_off_s;
    logic [TAG_W-1:0] cpu_tag_s;
    logic [IDX_W-1:0] ref_idx_s;
    logic [TAG_W-1:0] ref_tag_s;
    logic             hit_s;
    logic [31:0]      rdata_s;
    logic             unused_addr_s;

    assign cpu_off_s = bus.cpu_addr[2 +: OFF_W];
    assign cpu_idx_s = bus.cpu_addr[OFF_W+2 +: IDX_W];
    assign cpu_tag_s = bus.cpu_addr[31 -: TAG_W];
    // The refill address keeps the line's index and tag for the whole refill.
    assign ref_idx_s = mem_addr_q[OFF_W+2 +: IDX_W];
    assign ref_tag_s = mem_addr_q[31 -: TAG_W];
    assign unused_addr_s = &{1'b0, bus.cpu_addr[1:0]};

    assign bus.cpu_ready       = hit_s;
    assign bus.cpu_rdata       = rdata_s;
    assign bus.icache_mem_req  = mem_req_q;
    assign bus.icache_mem_addr = mem_addr_q;

    // Same-cycle lookup; no hit while refilling or while a flush is applied.
    always_comb begin
        hit_s   = 1'b0;
        rdata_s = 32'd0;
        if (bus.cpu_req && (state_q == ST_IDLE) && !bus.flush &&
            valid_q[cpu_idx_s] && (tag_q[cpu_idx_s] == cpu_tag_s)) begin
            hit_s   = 1'b1;
            rdata_s = data_q[cpu_idx_s][cpu_off_s];
        end else begin
            hit_s   = 1'b0;
            rdata_s = 32'd0;
        end
    end

    // Miss detection, refill sequencing, line install and flush handling.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        blank_d    = 1'b0;
        flushed_d  = flushed_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        data_d     = data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req && !hit_s && !bus.flush) begin
                    state_d    = ST_REFILL;
                    cnt_d      = CNT_ZERO;
                    blank_d    = 1'b1;
                    flushed_d  = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {bus.cpu_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                end else begin
                    mem_req_d  = 1'b0;
                end
            end
            ST_REFILL: begin
                if (bus.icache_mem_ready && !blank_q) begin
                    data_d[ref_idx_s][cnt_q] = bus.icache_mem_rdata;
                    if (cnt_q == CNT_LAST) begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                        tag_d[ref_idx_s] = ref_tag_s;
                        if (!flushed_q) begin
                            valid_d[ref_idx_s] = 1'b1;
                        end else begin
                            valid_d[ref_idx_s] = 1'b0;
                        end
                    end else begin
                        cnt_d      = cnt_q + CNT_ONE;
                        mem_addr_d = mem_addr_q + 32'd4;
                        blank_d    = 1'b1;
                    end
                end else begin
                    blank_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        // Flush overrides any install in the same cycle; an in-flight line stays invalid.
        if (bus.flush) begin
            valid_d = {NUM_LINES{1'b0}};
            if (state_q == ST_REFILL) begin
                flushed_d = 1'b1;
            end else begin
                flushed_d = flushed_q;
            end
        end else begin
            valid_d = valid_d;
        end
    end

    // Control state and valid bits, with synchronous reset abandoning any refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            blank_q    <= 1'b0;
            flushed_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
            valid_q    <= {NUM_LINES{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            blank_q    <= blank_d;
            flushed_q  <= flushed_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data storage; contents are qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the fetch stage and the instruction port of the unified memory subsystem. Hits return an instruction word combinationally in the request cycle. Misses refill a whole line, one word at a time, over the `icache_mem_*` req/ready handshake. A one-cycle flush invalidates all lines.

## Interface
- `NUM_LINES`, default 64: number of lines; power of two, at least 2.
- `LINE_WORDS`, default 4: 32-bit words per line; power of two, at least 2.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `cpu_req` input 1: fetch request.
- `cpu_addr` input 32: fetch byte address; bits [1:0] ignored.
- `cpu_rdata` output 32: instruction word; 0 whenever `cpu_ready`=0.
- `cpu_ready` output 1: `cpu_rdata` valid this cycle (combinational hit).
- `flush` input 1: invalidate all lines (fence.i).
- `icache_mem_req` output 1: refill word request (registered).
- `icache_mem_addr` output 32: refill word address, word-aligned (registered).
- `icache_mem_rdata` input 32: memory read data.
- `icache_mem_ready` input 1: memory data valid for the presented address.

## Operation
- Address split:
  - offset = bits [log2(LINE_WORDS)+1:2]
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits
- Storage: valid bit, tag and LINE_WORDS data words per line, all in flops or RAM readable combinationally.
- Hit: `cpu_req` & IDLE & valid[index] & tag match.
  - `cpu_ready`=1, `cpu_rdata`=data[index][offset], same cycle.
- FSM states: IDLE, REFILL.
- IDLE:
  - Hit: no state change.
  - Miss with `cpu_req`=1:
    - Latch line base (`cpu_addr` with offset and bits [1:0] zeroed).
    - Word counter := 0.
    - Go to REFILL.
    - Drive `icache_mem_req`=1 and `icache_mem_addr`=base from the next cycle.
- REFILL:
  - `cpu_ready`=0.
  - Each word's address is presented for at least one cycle before `icache_mem_ready` is honoured. The first cycle after any `icache_mem_addr` change is a blanking cycle; `icache_mem_ready` is ignored in it, because memory ready is registered and stale for one cycle.
  - On a qualified ready:
    - Write `icache_mem_rdata` into data[index][counter].
    - If counter < LINE_WORDS-1: counter+1, `icache_mem_addr` += 4, `icache_mem_req` stays 1.
    - If counter = LINE_WORDS-1: write tag, set valid[index], `icache_mem_req` := 0, go to IDLE.
- `cpu_addr` is held stable by the fetch stage while `cpu_req`=1 and `cpu_ready`=0.
- `cpu_req` dropping mid-refill does not abort; the line completes and is installed.
- Flush:
  - Clears every valid bit at the edge.
  - `cpu_ready`=0 in the flush cycle.
  - Flush during REFILL: refill runs to completion, but that line's valid bit is NOT set; the requester re-misses.
  - Flush in the final-word cycle: flush wins; the line is left invalid.
- Reset:
  - All valid bits cleared; state IDLE; counter 0.
  - Reset mid-refill abandons the refill; `icache_mem_req`=0 from the next cycle.

## Timing
- Reset values: `icache_mem_req`=0, `icache_mem_addr`=0, `cpu_ready`=0, `cpu_rdata`=0.
- Hit latency: 0 cycles (same cycle).
- Miss timing, with the standard memory model (ready visible 4 cycles after a new address is first presented):
  - Cycle 0: lookup misses.
  - Cycles 1..20: refill, 5 cycles per word for LINE_WORDS=4.
  - Cycle 21: lookup hits, `cpu_ready`=1.
- `icache_mem_req` stays high continuously for a whole refill and is low in IDLE.
- Address increments wrap only within the 32-bit space; a line never crosses its aligned base.

## Test plan
- Cold miss:
  - Stimulus: after reset, `cpu_req`=1, `cpu_addr`=0x0000_0104; memory holds word n = 0xA000_0000+n.
  - Required: `icache_mem_addr` steps 0x100, 0x104, 0x108, 0x10C; `cpu_ready`=1 with `cpu_rdata`=0xA000_0041 at cycle 21; `icache_mem_req` low from cycle 21.
- Hit after refill:
  - Stimulus: fetch 0x100, 0x108, 0x10C back-to-back.
  - Required: `cpu_ready`=1 each cycle; data 0xA000_0040, 0xA000_0042, 0xA000_0043; `icache_mem_req` stays 0.
- Conflict eviction:
  - Stimulus: fetch 0x104, then 0x104 + NUM_LINES×LINE_WORDS×4 (0x504), then 0x104.
  - Required: three refills; the final fetch misses again.
- Stale-ready blanking:
  - Stimulus: memory model keeps ready high one cycle after each address change.
  - Required: no word written in blanking cycles; line contents exactly 0xA000_0040..43.
- Flush mid-refill:
  - Stimulus: assert `flush` at cycle 8 of a refill of 0x200.
  - Required: refill completes; the next 0x200 fetch misses and re-refills; previously valid lines also miss.
- Reset mid-refill:
  - Stimulus: `rst` at cycle 7 of a refill.
  - Required: `icache_mem_req`=0 next cycle; a subsequent fetch of the same address performs a full refill.
